// File: rtl/matrix_token_input_if.sv
// UART byte input and matrix-storage command bus of the matrix entry block.
// master: token front end (drives wr_*, elem_cnt); slave: UART/storage side.
interface matrix_token_input_if #(
    parameter int DATA_W    = 8,
    parameter int ROW_IDX_W = 3,
    parameter int COL_IDX_W = 3
);
    logic [7:0]                     rx_data;
    logic                           rx_done;
    logic                           wr_cmd_new;
    logic [ROW_IDX_W-1:0]           wr_dims_r;
    logic [COL_IDX_W-1:0]           wr_dims_c;
    logic                           wr_cmd_single;
    logic [ROW_IDX_W-1:0]           wr_row_idx;
    logic [COL_IDX_W-1:0]           wr_col_idx;
    logic [DATA_W-1:0]              wr_data;
    logic [ROW_IDX_W+COL_IDX_W-1:0] elem_cnt;

    modport master (
        input  rx_data, rx_done,
        output wr_cmd_new, wr_dims_r, wr_dims_c, wr_cmd_single,
        output wr_row_idx, wr_col_idx, wr_data, elem_cnt
    );

    modport slave (
        output rx_data, rx_done,
        input  wr_cmd_new, wr_dims_r, wr_dims_c, wr_cmd_single,
        input  wr_row_idx, wr_col_idx, wr_data, elem_cnt
    );
endinterface

// File: rtl/matrix_token_input.sv
// UART matrix entry: parses signed decimal tokens into dims + row-major elements.
// Ports: clk, rst_n, start_en, btn_exit, bus (rx in / wr out), busy, err, err_code, input_done.
module matrix_token_input #(
    parameter int DATA_W         = 8,
    parameter int MAX_ROWS       = 5,
    parameter int MAX_COLS       = 5,
    parameter int ROW_IDX_W      = 3,
    parameter int COL_IDX_W      = 3,
    parameter int VAL_MIN        = -128,
    parameter int VAL_MAX        = 127,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_en,
    input  logic                        btn_exit,
    matrix_token_input_if.master        bus,
    output logic                        busy,
    output logic                        err,
    output logic [2:0]                  err_code,
    output logic                        input_done
);
    localparam int MW = DATA_W + 1;
    localparam int AW = DATA_W + 5;
    localparam int VW = DATA_W + 2;
    localparam int EW = ROW_IDX_W + COL_IDX_W;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0]        SAT   = AW'(1) << DATA_W;
    localparam logic signed [VW-1:0] V_MIN = VW'(VAL_MIN);
    localparam logic signed [VW-1:0] V_MAX = VW'(VAL_MAX);
    localparam logic signed [VW-1:0] R_MAX = VW'(MAX_ROWS);
    localparam logic signed [VW-1:0] C_MAX = VW'(MAX_COLS);
    localparam logic signed [VW-1:0] V_ONE = VW'(1);

    localparam logic [2:0] E_CHAR = 3'd1;
    localparam logic [2:0] E_DIM  = 3'd2;
    localparam logic [2:0] E_VAL  = 3'd3;
    localparam logic [2:0] E_MIN  = 3'd4;

    typedef enum logic [3:0] {
        IDLE, GET_M, GET_N, CREATE, GET_ELEM,
        WRITE, PAD, NEXT, ERROR, DONE
    } state_t;

    state_t state, state_d;
    logic [2:0] code_d;

    logic [MW-1:0]        mag;
    logic                 neg, has_dig, ovf, pad_mode;
    logic [TW-1:0]        timer;
    logic [ROW_IDX_W-1:0] dims_r, row;
    logic [COL_IDX_W-1:0] dims_c, col;
    logic [EW-1:0]        cnt;
    logic [DATA_W-1:0]    data;
    logic                 new_q, single_q;

    logic is_dig, is_min, is_term, pending, tok_st, rx_v, illegal;
    logic timeout, force_end, end_tok, last;
    logic latch_r, latch_c, latch_v, set_pad;
    logic [AW-1:0]        acc;
    logic signed [VW-1:0] value;

    assign is_dig  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_min  = bus.rx_data == 8'h2D;
    assign is_term = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h2C) ||
                     (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign pending = neg || has_dig;
    assign tok_st  = state inside {GET_M, GET_N, GET_ELEM};
    assign rx_v    = bus.rx_done && tok_st;
    // '-' is only legal as the first character of a token
    assign illegal = rx_v && !is_dig && !is_term && !(is_min && !pending);

    // a received byte always wins over timeout / forced padding
    assign timeout   = (state == GET_ELEM) && (timer == TW'(TIMEOUT_CYCLES));
    assign force_end = (state == GET_ELEM) && !bus.rx_done && (timeout || btn_exit);
    assign end_tok   = pending && ((rx_v && is_term) || force_end);

    assign acc   = AW'(mag) * AW'(10) + AW'(bus.rx_data[3:0]);
    assign value = neg ? -$signed(VW'(mag)) : $signed(VW'(mag));
    assign last  = (row == dims_r - ROW_IDX_W'(1)) &&
                   (col == dims_c - COL_IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_code <= 3'd0;
        end else begin
            state    <= state_d;
            err_code <= code_d;
        end
    end

    always_comb begin
        state_d = state;
        code_d  = err_code;
        latch_r = 1'b0;
        latch_c = 1'b0;
        latch_v = 1'b0;
        set_pad = 1'b0;
        if (!start_en) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE:   state_d = GET_M;
                GET_M: begin
                    if (illegal) begin
                        state_d = ERROR; code_d = E_CHAR;
                    end else if (end_tok) begin
                        if (!has_dig) begin
                            state_d = ERROR; code_d = E_MIN;
                        end else if (value >= V_ONE && value <= R_MAX) begin
                            latch_r = 1'b1; state_d = GET_N;
                        end else begin
                            state_d = ERROR; code_d = E_DIM;
                        end
                    end else if (btn_exit && !bus.rx_done && !pending) begin
                        state_d = DONE;
                    end
                end
                GET_N: begin
                    if (illegal) begin
                        state_d = ERROR; code_d = E_CHAR;
                    end else if (end_tok) begin
                        if (!has_dig) begin
                            state_d = ERROR; code_d = E_MIN;
                        end else if (value >= V_ONE && value <= C_MAX) begin
                            latch_c = 1'b1; state_d = CREATE;
                        end else begin
                            state_d = ERROR; code_d = E_DIM;
                        end
                    end
                end
                CREATE: state_d = GET_ELEM;
                GET_ELEM: begin
                    if (illegal) begin
                        state_d = ERROR; code_d = E_CHAR;
                    end else if (end_tok) begin
                        if (!has_dig) begin
                            state_d = ERROR; code_d = E_MIN;
                        end else if (ovf || value < V_MIN || value > V_MAX) begin
                            state_d = ERROR; code_d = E_VAL;
                        end else begin
                            latch_v = 1'b1;
                            set_pad = force_end;
                            state_d = WRITE;
                        end
                    end else if (force_end) begin
                        set_pad = 1'b1;
                        state_d = PAD;
                    end
                end
                WRITE, PAD: state_d = NEXT;
                NEXT: begin
                    if (last)          state_d = GET_M;
                    else if (pad_mode) state_d = PAD;
                    else               state_d = GET_ELEM;
                end
                ERROR, DONE: state_d = state;
                default: state_d = IDLE;
            endcase
        end
        if (state == IDLE) code_d = 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag      <= '0;
            neg      <= 1'b0;
            has_dig  <= 1'b0;
            ovf      <= 1'b0;
            pad_mode <= 1'b0;
            timer    <= '0;
            dims_r   <= '0;
            dims_c   <= '0;
            row      <= '0;
            col      <= '0;
            cnt      <= '0;
            data     <= '0;
            new_q    <= 1'b0;
            single_q <= 1'b0;
        end else begin
            // pulses are registered so a write lands two cycles after its terminator
            new_q    <= (state == CREATE) && start_en;
            single_q <= (state inside {WRITE, PAD}) && start_en;

            if (!tok_st || end_tok) begin
                mag     <= '0;
                neg     <= 1'b0;
                has_dig <= 1'b0;
                ovf     <= 1'b0;
            end else if (rx_v && is_dig) begin
                has_dig <= 1'b1;
                if (acc > SAT) begin
                    mag <= MW'(SAT);
                    ovf <= 1'b1;
                end else begin
                    mag <= acc[MW-1:0];
                end
            end else if (rx_v && is_min) begin
                neg <= 1'b1;
            end

            if (state != GET_ELEM || bus.rx_done) timer <= '0;
            else if (!timeout)                    timer <= timer + TW'(1);

            if (state inside {IDLE, CREATE} || (state == NEXT && last))
                pad_mode <= 1'b0;
            else if (set_pad)
                pad_mode <= 1'b1;

            if (latch_r) dims_r <= value[ROW_IDX_W-1:0];
            if (latch_c) dims_c <= value[COL_IDX_W-1:0];

            if (state == CREATE) begin
                row <= '0;
                col <= '0;
                cnt <= '0;
            end else if (state == NEXT) begin
                cnt <= cnt + EW'(1);
                if (col == dims_c - COL_IDX_W'(1)) begin
                    col <= '0;
                    row <= row + ROW_IDX_W'(1);
                end else begin
                    col <= col + COL_IDX_W'(1);
                end
            end

            if (latch_v)           data <= value[DATA_W-1:0];
            else if (state == PAD) data <= '0;
        end
    end

    assign bus.wr_cmd_new    = new_q;
    assign bus.wr_dims_r     = dims_r;
    assign bus.wr_dims_c     = dims_c;
    assign bus.wr_cmd_single = single_q;
    assign bus.wr_row_idx    = row;
    assign bus.wr_col_idx    = col;
    assign bus.wr_data       = data;
    assign bus.elem_cnt      = cnt;

    assign busy       = !(state inside {IDLE, DONE, ERROR});
    assign err        = state == ERROR;
    assign input_done = state == DONE;
endmodule

// File: tb/tb_matrix_token_input.sv
// Scoreboard bench for matrix_token_input: directed token strings, queued expectations.
// A negedge monitor pops create/write expectations whenever the DUT pulses.
module tb_matrix_token_input;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_en;
    logic       btn_exit;
    logic       busy, err, input_done;
    logic [2:0] err_code;

    matrix_token_input_if #(.DATA_W(8), .ROW_IDX_W(3), .COL_IDX_W(3)) bus ();

    matrix_token_input #(
        .DATA_W(8), .MAX_ROWS(5), .MAX_COLS(5), .ROW_IDX_W(3), .COL_IDX_W(3),
        .VAL_MIN(-128), .VAL_MAX(127), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en), .btn_exit(btn_exit),
        .bus(bus), .busy(busy), .err(err), .err_code(err_code),
        .input_done(input_done)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int c; int d; } wr_t;
    typedef struct { int r; int c; } new_t;

    wr_t  exp_wr[$];
    new_t exp_new[$];
    int   wr_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rx = 0;
    bit   lat_chk = 1'b0;
    wr_t  ew;
    new_t en;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.wr_cmd_new) begin
                checks++;
                if (exp_new.size() == 0) begin
                    failures++;
                    $display("FAIL new_unexpected got=%0dx%0d required=none",
                             bus.wr_dims_r, bus.wr_dims_c);
                end else begin
                    en = exp_new.pop_front();
                    if (int'(bus.wr_dims_r) != en.r || int'(bus.wr_dims_c) != en.c) begin
                        failures++;
                        $display("FAIL new_dims got=%0dx%0d required=%0dx%0d",
                                 bus.wr_dims_r, bus.wr_dims_c, en.r, en.c);
                    end
                end
            end
            if (bus.wr_cmd_single) begin
                wr_cyc.push_back(cyc);
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected got=(%0d,%0d)=%0d required=none",
                             bus.wr_row_idx, bus.wr_col_idx, $signed(bus.wr_data));
                end else begin
                    ew = exp_wr.pop_front();
                    if (int'(bus.wr_row_idx) != ew.r || int'(bus.wr_col_idx) != ew.c ||
                        int'($signed(bus.wr_data)) != ew.d) begin
                        failures++;
                        $display("FAIL wr_elem got=(%0d,%0d)=%0d required=(%0d,%0d)=%0d",
                                 bus.wr_row_idx, bus.wr_col_idx, $signed(bus.wr_data),
                                 ew.r, ew.c, ew.d);
                    end
                end
                if (lat_chk) begin
                    checks++;
                    if (cyc - last_rx != 2) begin
                        failures++;
                        $display("FAIL wr_latency got=%0d required=2", cyc - last_rx);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        last_rx = cyc;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic exp_n(input int r, input int c);
        new_t e;
        e.r = r; e.c = c;
        exp_new.push_back(e);
    endtask

    task automatic exp_w(input int r, input int c, input int d);
        wr_t e;
        e.r = r; e.c = c; e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_new.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, exp_wr.size() + exp_new.size(), 0);
    endtask

    task automatic start_blk();
        start_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic stop_blk();
        start_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic err_case(input string nm, input string s, input int code);
        start_blk();
        send_str(s);
        repeat (2) @(negedge clk);
        chk({nm, "_err"}, err, 1);
        chk({nm, "_code"}, err_code, code);
        chk({nm, "_busy"}, busy, 0);
        stop_blk();
        chk({nm, "_code_clr"}, err_code, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start_en = 1'b0; btn_exit = 1'b0;
        bus.rx_data = 8'h00; bus.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_done", input_done, 0);
        chk("rst_wr", bus.wr_cmd_single, 0);
        chk("rst_new", bus.wr_cmd_new, 0);
        chk("rst_cnt", bus.elem_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_blk();
        chk("start_busy", busy, 1);
        exp_n(2, 3);
        exp_w(0, 0, -5); exp_w(0, 1, 12); exp_w(0, 2, 0);
        exp_w(1, 0, 7);  exp_w(1, 1, -128); exp_w(1, 2, 127);
        send_str("2 3 ");
        lat_chk = 1'b1;
        send_str("-5,12,0,7,-128,127\n");
        drain("m23", 20);
        lat_chk = 1'b0;
        chk("m23_cnt", bus.elem_cnt, 6);
        chk("m23_busy", busy, 1);
        chk("m23_err", err, 0);

        exp_n(2, 2);
        exp_w(0, 0, 9); exp_w(0, 1, 0); exp_w(1, 0, 0); exp_w(1, 1, 0);
        send_str("2 2 ");
        send_str("9 ");
        drain("pad", 100);
        n = wr_cyc.size();
        chk("pad_gap_a", wr_cyc[n-1] - wr_cyc[n-2], 2);
        chk("pad_gap_b", wr_cyc[n-2] - wr_cyc[n-3], 2);
        chk("timeout_delay", wr_cyc[n-3] - wr_cyc[n-4], TO + 3);
        repeat (2) @(negedge clk);
        chk("pad_cnt", bus.elem_cnt, 4);
        chk("pad_busy", busy, 1);
        stop_blk();
        chk("stop_busy", busy, 0);

        exp_n(1, 2);
        err_case("val300", "1 2 300 ", 3);
        drain("val300", 5);
        err_case("dim6", "6 ", 2);
        err_case("char_x", "3 x", 1);
        err_case("minus_mid", "5-", 1);
        err_case("dim_neg", "1 -2 ", 2);
        exp_n(1, 1);
        err_case("lone_minus", "1 1 - ", 4);
        drain("lone", 5);

        start_blk();
        exp_n(1, 1);
        exp_w(0, 0, 4);
        send_str("1 1 ");
        send(8'h34);
        btn_exit = 1'b1;
        @(negedge clk);
        btn_exit = 1'b0;
        drain("btn", 10);
        repeat (20) @(negedge clk);
        chk("btn_busy", busy, 1);
        btn_exit = 1'b1;
        @(negedge clk);
        btn_exit = 1'b0;
        repeat (2) @(negedge clk);
        chk("exit_done", input_done, 1);
        chk("exit_busy", busy, 0);
        stop_blk();
        chk("exit_done_clr", input_done, 0);

        start_blk();
        exp_n(1, 1);
        exp_w(0, 0, 23);
        send_str("1 1 ");
        send(8'h32);
        repeat (TO - 1) @(negedge clk);
        send(8'h33);
        repeat (3) @(negedge clk);
        chk("race_nowr", exp_wr.size(), 1);
        lat_chk = 1'b1;
        send_str(" ");
        drain("race", 10);
        lat_chk = 1'b0;
        chk("race_cnt", bus.elem_cnt, 1);
        stop_blk();

        start_blk();
        exp_n(2, 2);
        exp_w(0, 0, 5);
        send_str("2 2 5 ");
        drain("drop", 10);
        stop_blk();
        repeat (TO + 10) @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_cnt", bus.elem_cnt, 1);

        start_blk();
        exp_n(3, 3);
        exp_w(0, 0, 1);
        send_str("3 3 1 ");
        drain("arst", 10);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cnt", bus.elem_cnt, 0);
        chk("arst_dims", bus.wr_dims_r, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_queues", exp_wr.size() + exp_new.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
